// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: operand width, the
// multiplier FSM state encoding and the common overflow rule.
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } calc_state_e;

  // Overflow rule shared by divider, adder and multiplier: a double-width
  // value overflows when anything above the low `width` bits is set.
  // The value is passed zero-extended to 64 bits so any width up to 32 fits.
  function automatic logic upper_nonzero(input logic [63:0] value, input int unsigned width);
    return |(value >> width);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add unsigned multiplier with a start/busy/done
// handshake. One partial product is accumulated per clock; latency is fixed
// at WIDTH cycles of CALC plus one DONE cycle.
module seq_multiplier
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   a1,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

  calc_state_e state_q, state_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;
  logic [2*WIDTH-1:0] acc_sum;

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      count_q    <= '0;
      product_q  <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      count_q    <= count_d;
      product_q  <= product_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic plus one add/shift step per CALC cycle.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    count_d    = count_q;
    product_d  = product_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    // Accumulator is double width, so this sum can never carry out.
    acc_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCalc;
          mcand_d  = {{WIDTH{1'b0}}, a0};
          mplier_d = a1;
          acc_d    = '0;
          count_d  = '0;
        end
      end
      StCalc: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == LastCount) begin
          state_d    = StDone;
          product_d  = acc_sum;
          overflow_d = upper_nonzero(64'(acc_sum), WIDTH);
          result_d   = overflow_d ? '0 : acc_sum[WIDTH-1:0];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    product  = product_q;
    result   = result_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and exhaustive checks for seq_multiplier (WIDTH=4).
module tb_seq_multiplier;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a0;
  logic [3:0] a1;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic [3:0] result;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_product = 8'h00;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] exp_p;
    logic [3:0] exp_r;
    logic       exp_o;
  } vec_t;

  seq_multiplier #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a0       (a0),
    .a1       (a1),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and follow it to completion. Cycle 1 is the cycle right
  // after the accept edge; done must appear in cycle 5 and last one cycle.
  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp_p,
                        input logic [3:0] exp_r, input logic exp_o, input string name);
    int   cyc;
    logic busy_ok;
    a0    = x;
    a1    = y;
    start = 1'b1;
    step();
    start = 1'b0;
    a0    = 4'($urandom);
    a1    = 4'($urandom);
    cyc   = 1;
    busy_ok = 1'b1;
    check({name, "_hold_at_accept"}, 32'(product), 32'(prev_product));
    while (!done && cyc < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'd5);
    check({name, "_busy"}, 32'({busy_ok, busy}), 32'b11);
    check({name, "_product"}, 32'(product), 32'(exp_p));
    check({name, "_result"}, 32'(result), 32'(exp_r));
    check({name, "_overflow"}, 32'(overflow), 32'(exp_o));
    prev_product = exp_p;
    step();
    check({name, "_done_pulse"}, 32'({done, busy}), 32'b00);
  endtask

  initial begin
    vec_t vecs[9];
    int   dones;
    int   cyc;

    vecs[0] = '{4'd3,  4'd5,  8'd15,  4'd15, 1'b0};
    vecs[1] = '{4'd15, 4'd15, 8'hE1,  4'd0,  1'b1};
    vecs[2] = '{4'd4,  4'd3,  8'd12,  4'd12, 1'b0};
    vecs[3] = '{4'd0,  4'd9,  8'd0,   4'd0,  1'b0};
    vecs[4] = '{4'd7,  4'd0,  8'd0,   4'd0,  1'b0};
    vecs[5] = '{4'd1,  4'd15, 8'd15,  4'd15, 1'b0};
    vecs[6] = '{4'd4,  4'd4,  8'd16,  4'd0,  1'b1};
    vecs[7] = '{4'd8,  4'd2,  8'd16,  4'd0,  1'b1};
    vecs[8] = '{4'd5,  4'd3,  8'd15,  4'd15, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a0    = 4'd0;
    a1    = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_outputs", 32'({product, result, overflow}), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].exp_p, vecs[i].exp_r, vecs[i].exp_o, $sformatf("vec%0d", i));
    end

    // start held high through CALC/DONE with operands changing: one done
    // pulse, then re-acceptance exactly at the first IDLE edge.
    a0    = 4'd2;
    a1    = 4'd6;
    start = 1'b1;
    step();
    dones = 0;
    for (int k = 1; k <= 7; k++) begin
      if (done) dones++;
      if (k < 5) begin
        a0 = 4'($urandom);
        a1 = 4'($urandom);
      end
      if (k == 5) begin
        check("hold_product", 32'(product), 32'd12);
        a0 = 4'd3;
        a1 = 4'd3;
      end
      if (k == 6) check("hold_idle_gap", 32'(busy), 32'd0);
      if (k == 7) begin
        check("hold_reaccept", 32'(busy), 32'd1);
        check("hold_single_done", 32'(dones), 32'd1);
        start = 1'b0;
      end else begin
        step();
      end
    end
    cyc = 1;
    while (!done && cyc < 20) begin
      step();
      cyc++;
    end
    check("reaccept_latency", 32'(cyc), 32'd5);
    check("reaccept_product", 32'(product), 32'd9);
    prev_product = 8'd9;
    step();

    // Reset in the second CALC cycle aborts the op with no done pulse.
    a0    = 4'd5;
    a1    = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_outputs", 32'({product, result, overflow}), 32'd0);
    // Start during reset must not be accepted.
    start = 1'b1;
    step();
    check("reset_beats_start", 32'(busy), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (done || busy) dones++;
      step();
    end
    check("abort_quiet", 32'(dones), 32'd0);
    prev_product = 8'd0;
    run_op(4'd2, 4'd2, 8'd4, 4'd4, 1'b0, "after_reset");

    // Exhaustive sweep against plain integer arithmetic.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        int p;
        p = x * y;
        run_op(4'(x), 4'(y), 8'(p), (p > 15) ? 4'd0 : 4'(p), (p > 15), "sweep");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
